data_write_buffer: RTL

Posted-write buffer between the CPU data-side SRAM-like port and the data AXI bridge (cpu_axi_interface). CPU stores are acknowledged after one cycle and drained in order to the bridge in the background. Loads are passed straight through, but only once every buffered and in-flight store has completed, so memory and MMIO ordering is preserved.

---
 rtl/data_write_buffer_pkg.sv | 29 ++
 rtl/data_write_buffer_if.sv | 48 ++++
 rtl/data_write_buffer_wb_fifo.sv | 64 ++++++
 rtl/data_write_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/data_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_write_buffer_pkg
// Purpose  : Shared types for the posted-write buffer: access size codes,
//            the buffered store entry and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package data_write_buffer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // One posted store: 32 b address, 2 b size, 32 b data (66 b total)
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/data_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : data_write_buffer_if
// Purpose  : CPU-side SRAM-like port and bridge-side request port of the
//            write buffer. The slave modport is the buffer itself; the master
//            modport is its environment (CPU plus AXI bridge).
// Revision : 1.0 - initial release
// ============================================================================
interface data_write_buffer_if;

  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  logic        wb_empty;

  modport slave (
    input  cpu_req, cpu_wr, cpu_size, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_addr_ok, cpu_data_ok,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_addr_ok, mem_data_ok,
    output wb_empty
  );

  modport master (
    output cpu_req, cpu_wr, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_addr_ok, cpu_data_ok,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_addr_ok, mem_data_ok,
    input  wb_empty
  );

endinterface
`default_nettype wire

// File: rtl/data_write_buffer_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO holding posted stores. Head is a registered
//            array read, so a pushed entry is visible the cycle after push.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic [WIDTH-1:0] din_i,
  output logic      [WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage, pointers (wrap naturally since DEPTH is a power of 2) and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_write_buffer
// Purpose  : Posted-write buffer between the CPU data port and the AXI
//            bridge. Stores are acked the next cycle and drained in order;
//            loads pass through only once all stores have fully completed.
// Revision : 1.0 - initial release
// ============================================================================
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  data_write_buffer_if.slave  bus
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  wb_state_t        state_q;
  wb_state_t        state_d;
  logic [OUT_W-1:0] out_cnt_q;
  logic [OUT_W-1:0] out_cnt_d;
  logic             wr_ack_q;
  logic             wr_ack_d;

  wb_entry_t        w_push_entry;
  logic [ENTRY_W-1:0] w_head_bits;
  wb_entry_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_dec;
  logic             w_rd_data_ok;

  assign w_push_entry = '{addr: bus.cpu_addr, size: bus.cpu_size, wdata: bus.cpu_wdata};
  assign w_head       = wb_entry_t'(w_head_bits);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_push_entry),
    .head_o  (w_head_bits),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Controller state, drained-write outstanding count and registered store ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      out_cnt_q <= '0;
      wr_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      wr_ack_q  <= wr_ack_d;
    end
  end

  // Next state and all handshake outputs; drain has priority over loads
  always_comb begin
    state_d         = state_q;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_rd_data_ok    = 1'b0;
    bus.cpu_addr_ok = 1'b0;
    bus.cpu_rdata   = '0;
    bus.mem_req     = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_size    = bus.cpu_size;
    bus.mem_addr    = bus.cpu_addr;
    bus.mem_wdata   = bus.cpu_wdata;
    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          if (out_cnt_q < OUT_W'(MAX_OUT)) begin
            bus.mem_req   = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_size  = w_head.size;
            bus.mem_addr  = w_head.addr;
            bus.mem_wdata = w_head.wdata;
            w_pop         = bus.mem_addr_ok;
          end
        end else if (out_cnt_q == '0) begin
          // Everything has retired: a load may go straight to the bridge
          bus.mem_req = bus.cpu_req && !bus.cpu_wr;
          if (bus.cpu_req && !bus.cpu_wr) begin
            bus.cpu_addr_ok = bus.mem_addr_ok;
            if (bus.mem_addr_ok) begin
              state_d = RD_WAIT;
            end
          end
        end
        // Slot availability uses the registered count only
        if (bus.cpu_req && bus.cpu_wr && !w_full) begin
          bus.cpu_addr_ok = 1'b1;
          w_push          = 1'b1;
        end
      end
      RD_WAIT: begin
        w_rd_data_ok  = bus.mem_data_ok;
        bus.cpu_rdata = bus.mem_rdata;
        if (bus.mem_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing is offered or accepted while reset is held
    if (reset) begin
      bus.cpu_addr_ok = 1'b0;
      bus.mem_req     = 1'b0;
      w_push          = 1'b0;
      w_pop           = 1'b0;
    end
  end

  assign wr_ack_d        = w_push;
  assign bus.cpu_data_ok = wr_ack_q || w_rd_data_ok;
  assign bus.wb_empty    = w_empty && (out_cnt_q == '0);

  // Saturating decrement absorbs stray write responses after reset
  assign w_dec = (state_q == IDLE) && bus.mem_data_ok && (out_cnt_q != '0);

  // Outstanding count: simultaneous issue and retire cancel out
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({w_pop, w_dec})
      2'b10:   out_cnt_d = out_cnt_q + OUT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - OUT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

endmodule
`default_nettype wire
